// File: rtl/count_wrap_monitor_if.sv
// -----------------------------------------------------------------------------
// count_wrap_monitor_if
//
// Purpose: bundles the counter-side signals observed by count_wrap_monitor and
//          the monitor's result outputs.
//
// Signals:
//   count_in        counter's 8-bit count output
//   dir_up_in       counter's direction input (1 = up), same cycle it is applied
//   load_en_in      counter's load enable, same cycle it is applied
//   cnt_reset_in    active-high mirror of the counter's reset
//   clr_in          clears tally and error, re-seeds tracking
//   wrap_up_pulse   one-cycle pulse per HIGH->LOW wrap
//   wrap_down_pulse one-cycle pulse per LOW->HIGH wrap
//   wrap_count      saturating tally of both wrap kinds
//   err_flag        sticky error
//   err_code        first error cause: 01 range, 10 step, 00 none
//
// Modports:
//   master  side that drives the counter signals and reads the results
//   slave   the monitor itself
// -----------------------------------------------------------------------------
interface count_wrap_monitor_if #(
    parameter int unsigned WRAP_W = 16
);
    logic [7:0]        count_in;
    logic              dir_up_in;
    logic              load_en_in;
    logic              cnt_reset_in;
    logic              clr_in;
    logic              wrap_up_pulse;
    logic              wrap_down_pulse;
    logic [WRAP_W-1:0] wrap_count;
    logic              err_flag;
    logic [1:0]        err_code;

    modport master (
        output count_in,
        output dir_up_in,
        output load_en_in,
        output cnt_reset_in,
        output clr_in,
        input  wrap_up_pulse,
        input  wrap_down_pulse,
        input  wrap_count,
        input  err_flag,
        input  err_code
    );

    modport slave (
        input  count_in,
        input  dir_up_in,
        input  load_en_in,
        input  cnt_reset_in,
        input  clr_in,
        output wrap_up_pulse,
        output wrap_down_pulse,
        output wrap_count,
        output err_flag,
        output err_code
    );
endinterface

// File: rtl/count_wrap_monitor.sv
// -----------------------------------------------------------------------------
// count_wrap_monitor
//
// Purpose: checker/statistics stage placed after the LOW..HIGH up/down counter.
//          Tracks every count transition, pulses on up-wraps (HIGH->LOW) and
//          down-wraps (LOW->HIGH), keeps a saturating wrap tally and latches a
//          sticky error with the code of the first failure.
//
// Ports:
//   clk          rising-edge clock shared with the counter
//   reset_ah_in  synchronous active-high reset (priority over clr_in)
//   mon          count_wrap_monitor_if.slave: counter observation inputs,
//                clr_in, and the registered result outputs
//
// Parameters:
//   LOW, HIGH    legal count range bounds (inclusive)
//   WRAP_W       width of the wrap tally
//
// Build option:
//   COUNT_MON_STEP_CHECK_EN  when defined, illegal steps are reported as error
//                            code 10; when undefined only range errors are
//                            detected. Wrap detection is identical in both.
// -----------------------------------------------------------------------------
module count_wrap_monitor #(
    parameter logic [7:0]  LOW    = 8'd10,
    parameter logic [7:0]  HIGH   = 8'd40,
    parameter int unsigned WRAP_W = 16
) (
    input logic                 clk,
    input logic                 reset_ah_in,
    count_wrap_monitor_if.slave mon
);

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        TRACK = 2'd1,
        ERROR = 2'd2
    } state_t;

    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_RANGE = 2'b01;
    localparam logic [1:0] CODE_STEP  = 2'b10;

    state_t            r_state;
    logic [7:0]        r_prev_count;
    logic              r_dir_d;
    logic              r_load_d;
    logic              r_rst_d;
    logic              r_wrap_up;
    logic              r_wrap_down;
    logic [WRAP_W-1:0] r_wrap_count;
    logic              r_err_flag;
    logic [1:0]        r_err_code;

    state_t            w_state_nxt;
    logic              w_wrap_up_nxt;
    logic              w_wrap_down_nxt;
    logic [WRAP_W-1:0] w_wrap_count_nxt;
    logic              w_err_flag_nxt;
    logic [1:0]        w_err_code_nxt;

    logic              w_tracking;
    logic              w_exempt;
    logic              w_range_err;
    logic              w_step_err;
    logic              w_up_wrap;
    logic              w_down_wrap;
    logic              w_any_err;

    // -------------------------------------------------------------------------
    // Sample classification. The registered controls (r_*_d) are the ones the
    // counter saw on the edge that produced the count now being sampled.
    // -------------------------------------------------------------------------
    always_comb begin
        w_tracking  = (r_state != INIT);
        w_exempt    = r_load_d | r_rst_d;
        w_range_err = (mon.count_in < LOW) || (mon.count_in > HIGH);

        w_up_wrap   = w_tracking && !w_exempt && r_dir_d &&
                      (r_prev_count == HIGH) && (mon.count_in == LOW);
        w_down_wrap = w_tracking && !w_exempt && !r_dir_d &&
                      (r_prev_count == LOW) && (mon.count_in == HIGH);
    end

`ifdef COUNT_MON_STEP_CHECK_EN
    logic w_legal_step;

    always_comb begin
        if (r_dir_d) begin
            w_legal_step = (r_prev_count < HIGH) &&
                           (mon.count_in == r_prev_count + 8'd1);
        end else begin
            w_legal_step = (r_prev_count > LOW) &&
                           (mon.count_in == r_prev_count - 8'd1);
        end
        w_step_err = w_tracking && !w_exempt && !w_legal_step &&
                     !w_up_wrap && !w_down_wrap;
    end
`else
    always_comb begin
        w_step_err = 1'b0;
    end
`endif

    assign w_any_err = w_range_err | w_step_err;

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_wrap_up_nxt    = 1'b0;
        w_wrap_down_nxt  = 1'b0;
        w_wrap_count_nxt = r_wrap_count;
        w_err_flag_nxt   = r_err_flag;
        w_err_code_nxt   = r_err_code;

        if (mon.clr_in) begin
            // Clear overrides any error or wrap seen on the same sample.
            w_state_nxt      = INIT;
            w_wrap_count_nxt = '0;
            w_err_flag_nxt   = 1'b0;
            w_err_code_nxt   = CODE_NONE;
        end else begin
            case (r_state)
                INIT:    w_state_nxt = w_range_err ? ERROR : TRACK;
                TRACK:   w_state_nxt = w_any_err ? ERROR : TRACK;
                ERROR:   w_state_nxt = ERROR;
                default: w_state_nxt = INIT;
            endcase

            // Wraps are gated off in INIT, so this also holds in ERROR.
            w_wrap_up_nxt   = w_up_wrap;
            w_wrap_down_nxt = w_down_wrap;
            if ((w_up_wrap || w_down_wrap) && (r_wrap_count != '1)) begin
                w_wrap_count_nxt = r_wrap_count + 1'b1;
            end

            if (w_any_err) begin
                w_err_flag_nxt = 1'b1;
                // First error wins; range takes precedence within one sample.
                if (r_err_code == CODE_NONE) begin
                    w_err_code_nxt = w_range_err ? CODE_RANGE : CODE_STEP;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset_ah_in) begin
            r_state      <= INIT;
            r_prev_count <= '0;
            r_dir_d      <= 1'b0;
            r_load_d     <= 1'b0;
            r_rst_d      <= 1'b0;
            r_wrap_up    <= 1'b0;
            r_wrap_down  <= 1'b0;
            r_wrap_count <= '0;
            r_err_flag   <= 1'b0;
            r_err_code   <= CODE_NONE;
        end else begin
            r_state      <= w_state_nxt;
            r_prev_count <= mon.count_in;
            r_dir_d      <= mon.dir_up_in;
            r_load_d     <= mon.load_en_in;
            r_rst_d      <= mon.cnt_reset_in;
            r_wrap_up    <= w_wrap_up_nxt;
            r_wrap_down  <= w_wrap_down_nxt;
            r_wrap_count <= w_wrap_count_nxt;
            r_err_flag   <= w_err_flag_nxt;
            r_err_code   <= w_err_code_nxt;
        end
    end

    assign mon.wrap_up_pulse   = r_wrap_up;
    assign mon.wrap_down_pulse = r_wrap_down;
    assign mon.wrap_count      = r_wrap_count;
    assign mon.err_flag        = r_err_flag;
    assign mon.err_code        = r_err_code;

endmodule

// File: tb/tb_count_wrap_monitor.sv
// -----------------------------------------------------------------------------
// tb_count_wrap_monitor
//
// Purpose: self-checking bench for count_wrap_monitor. A table of per-edge
//          counter traces with hand-computed results, followed by hand-written
//          sequences for tally saturation and mid-run reset.
//          Expectations for step errors follow COUNT_MON_STEP_CHECK_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_count_wrap_monitor;

    localparam int unsigned WRAP_W = 16;

`ifdef COUNT_MON_STEP_CHECK_EN
    localparam logic       STEP_EN   = 1'b1;
    localparam logic [1:0] STEP_CODE = 2'b10;
`else
    localparam logic       STEP_EN   = 1'b0;
    localparam logic [1:0] STEP_CODE = 2'b00;
`endif

    logic clk = 1'b0;
    logic reset_ah_in;

    always #5 clk = ~clk;

    count_wrap_monitor_if #(.WRAP_W(WRAP_W)) mif ();

    count_wrap_monitor #(
        .LOW   (8'd10),
        .HIGH  (8'd40),
        .WRAP_W(WRAP_W)
    ) dut (
        .clk        (clk),
        .reset_ah_in(reset_ah_in),
        .mon        (mif)
    );

    // One row = inputs presented at an edge, results expected after that edge.
    typedef struct {
        logic [7:0]  cnt;
        logic        dir;
        logic        ld;
        logic        crst;
        logic        clr;
        logic        up;
        logic        dn;
        logic [15:0] wc;
        logic        ef;
        logic [1:0]  ec;
    } vec_t;

    vec_t vecs[$];
    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    task automatic add(input logic [7:0] c, input logic d, input logic ld,
                       input logic cr, input logic cl, input logic up,
                       input logic dn, input logic [15:0] wc,
                       input logic ef, input logic [1:0] ec);
        vec_t v;
        v.cnt = c; v.dir = d; v.ld = ld; v.crst = cr; v.clr = cl;
        v.up = up; v.dn = dn; v.wc = wc; v.ef = ef; v.ec = ec;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [7:0] c, input logic d, input logic ld,
                         input logic cr, input logic cl);
        @(negedge clk);
        mif.count_in     = c;
        mif.dir_up_in    = d;
        mif.load_en_in   = ld;
        mif.cnt_reset_in = cr;
        mif.clr_in       = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic up, input logic dn,
                         input logic [15:0] wc, input logic ef,
                         input logic [1:0] ec);
        n_checks++;
        if ({mif.wrap_up_pulse, mif.wrap_down_pulse, mif.wrap_count,
             mif.err_flag, mif.err_code} !== {up, dn, wc, ef, ec}) begin
            n_fails++;
            $display("FAIL %s: got up=%0b dn=%0b wc=%0d ef=%0b ec=%b, expected up=%0b dn=%0b wc=%0d ef=%0b ec=%b",
                     name, mif.wrap_up_pulse, mif.wrap_down_pulse,
                     mif.wrap_count, mif.err_flag, mif.err_code,
                     up, dn, wc, ef, ec);
        end
    endtask

    initial begin
        // ---------------- vector table ----------------
        // Up run from 10: wraps at samples 31, 62, 93.
        for (int k = 0; k <= 93; k++) begin
            add(8'(10 + k % 31), 1'b1, 1'b0, 1'b0, 1'b0,
                (k > 0) && (k % 31 == 0), 1'b0, 16'(k / 31), 1'b0, 2'b00);
        end
        // Turn around at 12 and down-wrap 10 -> 40.
        add(8'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 1'b0, 2'b00);
        add(8'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 1'b0, 2'b00);
        add(8'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 1'b0, 2'b00);
        add(8'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 1'b0, 2'b00);
        add(8'd40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd4, 1'b0, 2'b00);
        for (int j = 39; j >= 34; j--) begin
            add(8'(j), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4, 1'b0, 2'b00);
        end
        // Load 25 while at 33, continue up.
        add(8'd33, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4, 1'b0, 2'b00);
        add(8'd25, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4, 1'b0, 2'b00);
        add(8'd26, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4, 1'b0, 2'b00);
        // Load 20, then jump 20 -> 23 without load.
        add(8'd27, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4, 1'b0, 2'b00);
        add(8'd20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4, 1'b0, 2'b00);
        add(8'd23, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4, STEP_EN, STEP_CODE);
        add(8'd24, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4, STEP_EN, STEP_CODE);
        // Clear, re-seed, then load 50.
        add(8'd25, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 2'b00);
        add(8'd26, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 2'b00);
        add(8'd50, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 2'b01);
        // Recovery 50 -> 10 is a step error but the range code stays.
        add(8'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 2'b01);
        for (int v = 11; v <= 40; v++) begin
            add(8'(v), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 2'b01);
        end
        // Wrap while in error still counts.
        add(8'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1, 1'b1, 2'b01);
        for (int v = 11; v <= 40; v++) begin
            add(8'(v), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 1'b1, 2'b01);
        end
        // Clear on a wrap sample: clear wins, no pulse.
        add(8'd10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 2'b00);
        // Counter reset exempts the following sample.
        add(8'd11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 2'b00);
        add(8'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 2'b00);
        // Loaded 9 is below range.
        add(8'd11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 2'b00);
        add(8'd9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 2'b01);
        add(8'd10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 2'b00);
        // 41 on the INIT sample is a range error.
        add(8'd41, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 2'b01);
        add(8'd10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 2'b00);
        // Down-direction step error 12 -> 14.
        add(8'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 2'b00);
        add(8'd14, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, STEP_EN, STEP_CODE);
        add(8'd15, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 2'b00);
        // Range and step on the same sample: range code captured.
        add(8'd20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 2'b00);
        add(8'd45, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 2'b01);
        add(8'd10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 2'b00);

        // ---------------- reset ----------------
        reset_ah_in = 1'b1;
        drive(8'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(8'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        check("reset", 1'b0, 1'b0, 16'd0, 1'b0, 2'b00);
        reset_ah_in = 1'b0;

        // ---------------- table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].cnt, vecs[i].dir, vecs[i].ld, vecs[i].crst, vecs[i].clr);
            check($sformatf("vec[%0d] cnt=%0d", i, vecs[i].cnt),
                  vecs[i].up, vecs[i].dn, vecs[i].wc, vecs[i].ef, vecs[i].ec);
        end

        // ---------------- tally saturation ----------------
        // Alternating 40/10 with matching direction wraps on every sample.
        drive(8'd40, 1'b1, 1'b0, 1'b0, 1'b0);
        check("sat_seed", 1'b0, 1'b0, 16'd0, 1'b0, 2'b00);
        for (int i = 1; i <= 65537; i++) begin
            if (i % 2 == 1) drive(8'd10, 1'b0, 1'b0, 1'b0, 1'b0);
            else            drive(8'd40, 1'b1, 1'b0, 1'b0, 1'b0);
            case (i)
                1:     check("sat_first_up",  1'b1, 1'b0, 16'd1,    1'b0, 2'b00);
                2:     check("sat_first_dn",  1'b0, 1'b1, 16'd2,    1'b0, 2'b00);
                1000:  check("sat_mid",       1'b0, 1'b1, 16'd1000, 1'b0, 2'b00);
                65534: check("sat_below_max", 1'b0, 1'b1, 16'hFFFE, 1'b0, 2'b00);
                65535: check("sat_reach_max", 1'b1, 1'b0, 16'hFFFF, 1'b0, 2'b00);
                65536: check("sat_hold_dn",   1'b0, 1'b1, 16'hFFFF, 1'b0, 2'b00);
                65537: check("sat_hold_up",   1'b1, 1'b0, 16'hFFFF, 1'b0, 2'b00);
                default: ;
            endcase
        end

        // ---------------- mid-run reset (with clear also high) ----------------
        reset_ah_in = 1'b1;
        drive(8'd40, 1'b1, 1'b0, 1'b0, 1'b1);
        check("reset_mid", 1'b0, 1'b0, 16'd0, 1'b0, 2'b00);
        reset_ah_in = 1'b0;
        drive(8'd40, 1'b1, 1'b0, 1'b0, 1'b0);
        check("post_reset_init", 1'b0, 1'b0, 16'd0, 1'b0, 2'b00);
        drive(8'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        check("post_reset_wrap", 1'b1, 1'b0, 16'd1, 1'b0, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
